// File: rtl/pre_if_stage_pkg.sv
// rtl/pre_if_stage_pkg.sv - shared CPU constants for the pre-IF fetch stage
//
// Purpose : FSM state encoding and reset fetch address used by pre_if_stage.
// Contents: PIF_SEQ / PIF_WAIT_DS / PIF_REDIRECT state constants,
//           CPU_RESET_PC boot vector, PIF_STATE_W state register width.

package pre_if_stage_pkg;

    localparam int PIF_STATE_W = 2;

    // Sequential fetch; also the only state when branch prediction is absent.
    localparam logic [PIF_STATE_W-1:0] PIF_SEQ      = 2'd0;
    // A taken prediction is pending; fetch_pc is the branch delay slot.
    localparam logic [PIF_STATE_W-1:0] PIF_WAIT_DS  = 2'd1;
    // fetch_pc holds the predicted target; back to SEQ once it is handed off.
    localparam logic [PIF_STATE_W-1:0] PIF_REDIRECT = 2'd2;

    localparam logic [31:0] CPU_RESET_PC = 32'hbfc00000;

endpackage

// File: rtl/pre_if_stage.sv
// rtl/pre_if_stage.sv - pre-IF stage: fetch PC generation and instruction request
//
// Purpose : Owns fetch_pc, issues instruction-memory address requests and hands
//           accepted PCs to IF. Follows taken branch predictions after their
//           delay slot and honours EX redirects with top priority.
// Macro   : BRANCH_PREDICT_EN - when defined, bp_* inputs steer fetch through
//           SEQ -> WAIT_DS -> REDIRECT; when undefined, bp_* inputs are ignored
//           and fetch is purely sequential apart from EX redirects.
// Ports   : clk, reset (sync, active-high)
//           if_allowin                          - IF can take a new PC
//           inst_req / inst_addr / inst_addr_ok - instruction-memory address handshake
//           pre_if_to_if_valid / pc_pre_if / adel_pre_if - handoff to IF
//           bp_valid_IF / bp_miss_IF / bp_state_IF / bp_pc_target_IF - IF predictor result
//           ex_redirect_en / ex_redirect_pc     - EX flush / mispredict correction

module pre_if_stage
    import pre_if_stage_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(CPU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_allowin,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_addr_ok,
    output logic                  pre_if_to_if_valid,
    output logic [ADDR_WIDTH-1:0] pc_pre_if,
    output logic                  adel_pre_if,
    input  logic                  bp_valid_IF,
    input  logic                  bp_miss_IF,
    input  logic                  bp_state_IF,
    input  logic [ADDR_WIDTH-1:0] bp_pc_target_IF,
    input  logic                  ex_redirect_en,
    input  logic [ADDR_WIDTH-1:0] ex_redirect_pc
);

    logic [ADDR_WIDTH-1:0]  fetch_pc;
    logic [ADDR_WIDTH-1:0]  pending_target;
    logic [PIF_STATE_W-1:0] state;

    logic                   aligned;
    logic                   handoff;
    logic [ADDR_WIDTH-1:0]  seq_pc;

    assign aligned = (fetch_pc[1:0] == 2'b00);
    assign seq_pc  = fetch_pc + ADDR_WIDTH'(4);

    assign inst_req  = if_allowin & ~ex_redirect_en & ~reset & aligned;
    assign inst_addr = fetch_pc;

    // A misaligned PC never reaches memory; it is handed to IF directly so the
    // AdEL exception travels down the pipe with it.
    assign handoff = aligned ? (inst_req & inst_addr_ok)
                             : (if_allowin & ~ex_redirect_en & ~reset);

    assign pre_if_to_if_valid = handoff;
    assign pc_pre_if          = fetch_pc;
    assign adel_pre_if        = ~aligned;

`ifdef BRANCH_PREDICT_EN
    logic bp_take;

    // Only a hit predicted taken, seen while fetching sequentially, starts a redirect.
    assign bp_take = (state == PIF_SEQ) & bp_valid_IF & ~bp_miss_IF & bp_state_IF;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            pending_target <= '0;
            state          <= PIF_SEQ;
        end else if (ex_redirect_en) begin
            fetch_pc <= ex_redirect_pc;
            state    <= PIF_SEQ;
        end else begin
            case (state)
                PIF_SEQ: begin
                    if (bp_take && handoff) begin
                        // Delay slot leaves this same cycle: jump straight to the target.
                        fetch_pc <= bp_pc_target_IF;
                        state    <= PIF_REDIRECT;
                    end else if (bp_take) begin
                        pending_target <= bp_pc_target_IF;
                        state          <= PIF_WAIT_DS;
                    end else if (handoff) begin
                        fetch_pc <= seq_pc;
                    end
                end
                PIF_WAIT_DS: begin
                    if (handoff) begin
                        fetch_pc <= pending_target;
                        state    <= PIF_REDIRECT;
                    end
                end
                PIF_REDIRECT: begin
                    if (handoff) begin
                        fetch_pc <= seq_pc;
                        state    <= PIF_SEQ;
                    end
                end
                default: state <= PIF_SEQ;
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc       <= RESET_PC;
            pending_target <= '0;
            state          <= PIF_SEQ;
        end else if (ex_redirect_en) begin
            fetch_pc <= ex_redirect_pc;
            state    <= PIF_SEQ;
        end else if (handoff) begin
            fetch_pc <= seq_pc;
        end
    end

    // Predictor inputs and the redirect registers have no consumer in this build.
    logic bp_unused;
    assign bp_unused = &{1'b0, bp_valid_IF, bp_miss_IF, bp_state_IF, bp_pc_target_IF,
                         pending_target, state};
`endif

endmodule
